// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver.
//   state_t         - receiver FSM states
//   PS2_DATA_BITS   - data bits per frame
//   PS2_FRAME_BITS  - total bits per frame (start + data + parity + stop)
//   PS2_FILTER_LEN_DEF / PS2_TIMEOUT_CYCLES_DEF - default parameter values
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int unsigned PS2_DATA_BITS          = 8;
    localparam int unsigned PS2_FRAME_BITS         = 11;
    localparam int unsigned PS2_FILTER_LEN_DEF     = 8;
    localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 50000;

endpackage

// File: rtl/ps2_input_filter.sv
// Input conditioning for the PS/2 lines.
//   CLK, RST  - system clock, asynchronous active-low reset
//   ps2clk    - raw PS/2 clock line (asynchronous)
//   ps2data   - raw PS/2 data line (asynchronous)
//   fall      - one-cycle pulse when the filtered clock goes 1->0
//   data      - synchronized data, delayed to line up with the filtered clock
module ps2_input_filter import ps2_pkg::*; #(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic ps2clk,
    input  logic ps2data,
    output logic fall,
    output logic data
);

    localparam int unsigned CntW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] data_dly;
    logic [CntW-1:0]       stable_cnt;
    logic                  filt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            data_dly   <= '1;
            stable_cnt <= '0;
            filt       <= 1'b1;
            fall       <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2clk};
            data_sync <= {data_sync[0], ps2data};
            // Data takes the same FILTER_LEN-cycle path as the clock filter.
            data_dly  <= {data_dly[FILTER_LEN-2:0], data_sync[1]};
            fall      <= 1'b0;
            if (clk_sync[1] == filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CntW'(FILTER_LEN - 1)) begin
                // FILTER_LEN consecutive differing samples: accept the new level.
                filt       <= clk_sync[1];
                stable_cnt <= '0;
                fall       <= filt;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign data = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver.
//   CLK, RST    - system clock, asynchronous active-low reset
//   ps2clk      - raw PS/2 clock line
//   ps2data     - raw PS/2 data line
//   byte_out    - last good byte (LSB first on the wire), held until next good frame
//   byte_valid  - one-cycle strobe, byte_out new in the same cycle
//   parity_err  - one-cycle strobe on an odd-parity failure
//   frame_err   - one-cycle strobe on a bad stop bit or inter-bit timeout
module ps2_frame_receiver import ps2_pkg::*; #(
    parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned ReqW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ToW  = (ReqW > 16) ? ReqW : 16;

    logic                     fall;
    logic                     data;
    state_t                   state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift;
    logic                     parity_bit;
    logic [ToW-1:0]           to_cnt;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .CLK     (CLK),
        .RST     (RST),
        .ps2clk  (ps2clk),
        .ps2data (ps2data),
        .fall    (fall),
        .data    (data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                // to_cnt holds cycles elapsed since the last fall event, so the
                // timeout strobe lands exactly TIMEOUT_CYCLES cycles after it.
                to_cnt <= ToW'(1);
                unique case (state)
                    IDLE: begin
                        if (!data) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift[bit_cnt] <= data;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!(^{shift, parity_bit})) begin
                            parity_err <= 1'b1;
                        end else if (!data) begin
                            frame_err <= 1'b1;
                        end else begin
                            byte_out   <= shift;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

    localparam int unsigned F    = 4;
    localparam int unsigned T    = 300;
    localparam int unsigned H    = 40;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;

    int         valid_cnt = 0;
    int         perr_cnt  = 0;
    int         ferr_cnt  = 0;
    logic [7:0] got_bytes[$];

    ps2_frame_receiver #(
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (byte_valid) begin
            valid_cnt++;
            got_bytes.push_back(byte_out);
        end
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One device bit: data set while clock high, then a low phase.
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge CLK);
        ps2data = b;
        if (glitch) begin
            wait_cycles(H / 2);
            ps2clk = 1'b0;
            wait_cycles(F - 1);
            ps2clk = 1'b1;
            wait_cycles(H / 2 - (F - 1));
            ps2clk = 1'b0;
            wait_cycles(H / 2);
            ps2clk = 1'b1;
            wait_cycles(F - 1);
            ps2clk = 1'b0;
            wait_cycles(H / 2 - (F - 1));
        end else begin
            wait_cycles(H);
            ps2clk = 1'b0;
            wait_cycles(H);
        end
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(par, glitch);
        send_bit(stp, glitch);
    endtask

    // Drive a falling edge now and count rising CLK edges until the strobe is seen.
    task automatic fall_and_count(input bit want_frame_err, output int n);
        ps2clk = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (want_frame_err ? frame_err : byte_valid) break;
        end
    endtask

    initial begin
        int n;
        int base;

        RST     = 1'b0;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cycles(5);
        check("reset_byte_out", 32'(byte_out), 32'h00);
        check("reset_byte_valid", 32'(byte_valid), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        RST = 1'b1;
        wait_cycles(10);

        // 0x1C good frame, measuring strobe latency from the stop-bit edge.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h1C >> i), 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge CLK);
        ps2data = 1'b1;
        wait_cycles(H);
        fall_and_count(1'b0, n);
        check("valid_latency", 32'(n), 32'(F + 3));
        wait_cycles(H);
        ps2clk = 1'b1;
        wait_cycles(H);
        check("1c_byte_out", 32'(byte_out), 32'h1C);
        check("1c_valid_cnt", 32'(valid_cnt), 32'd1);
        check("1c_perr_cnt", 32'(perr_cnt), 32'd0);
        check("1c_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Reset mid-frame after 4 bits.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        wait_cycles(5);
        RST = 1'b0;
        ps2data = 1'b1;
        wait_cycles(3);
        check("midreset_byte_out", 32'(byte_out), 32'h00);
        RST = 1'b1;
        wait_cycles(2 * H);
        check("midreset_valid_cnt", 32'(valid_cnt), 32'd1);
        check("midreset_err_cnt", 32'(perr_cnt + ferr_cnt), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_cycles(H);
        check("after_reset_byte_out", 32'(byte_out), 32'h1C);
        check("after_reset_valid_cnt", 32'(valid_cnt), 32'd2);

        // Back-to-back F0 then 1C.
        base = got_bytes.size();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_cycles(H);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd4);
        check("b2b_first", 32'(got_bytes[base]), 32'hF0);
        check("b2b_second", 32'(got_bytes[base + 1]), 32'h1C);
        check("b2b_err_cnt", 32'(perr_cnt + ferr_cnt), 32'd0);

        // 0x29 with sub-threshold glitches on the clock line.
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        wait_cycles(H);
        check("glitch_byte_out", 32'(byte_out), 32'h29);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd5);
        check("glitch_err_cnt", 32'(perr_cnt + ferr_cnt), 32'd0);

        // 0x1C with wrong parity.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        wait_cycles(H);
        check("parity_perr_cnt", 32'(perr_cnt), 32'd1);
        check("parity_valid_cnt", 32'(valid_cnt), 32'd5);
        check("parity_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("parity_byte_held", 32'(byte_out), 32'h29);

        // 0x5A with bad stop bit.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_cycles(H);
        check("stop_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("stop_perr_cnt", 32'(perr_cnt), 32'd1);
        check("stop_valid_cnt", 32'(valid_cnt), 32'd5);
        check("stop_byte_held", 32'(byte_out), 32'h29);

        // Clock stops after 5 bits: timeout measured from the last edge.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h1C >> i), 1'b0);
        @(negedge CLK);
        ps2data = 1'b1;
        wait_cycles(H);
        fall_and_count(1'b1, n);
        check("timeout_latency", 32'(n), 32'(F + 2 + T));
        ps2clk = 1'b1;
        wait_cycles(H);
        check("timeout_ferr_cnt", 32'(ferr_cnt), 32'd2);
        check("timeout_valid_cnt", 32'(valid_cnt), 32'd5);

        // Start bit of 1 is ignored and never times out.
        send_bit(1'b1, 1'b0);
        wait_cycles(T + 50);
        check("spurious_start_strobes", 32'(valid_cnt + perr_cnt + ferr_cnt), 32'd8);

        // Receiver still works after all the faults.
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        wait_cycles(H);
        check("final_byte_out", 32'(byte_out), 32'hF0);
        check("final_valid_cnt", 32'(valid_cnt), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
